// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module : multicycle_control_if
// Brief  : Instruction-field, ALU-flag and control-strobe bundle between the
//          multicycle controller and its datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero_Flag;

    logic [3:0] ALU_Ctl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       Illegal;
    logic [3:0] State;

    // Controller side: consumes instruction fields, drives control strobes
    modport master (
        input  Opcode, Funct, Zero_Flag,
        output ALU_Ctl, ALUSrcA, ALUSrcB, PCSource, PCWrite, IorD, MemRead,
               MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, Illegal, State
    );

    // Datapath side
    modport slave (
        output Opcode, Funct, Zero_Flag,
        input  ALU_Ctl, ALUSrcA, ALUSrcB, PCSource, PCWrite, IorD, MemRead,
               MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, Illegal, State
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module : multicycle_control
// Brief  : Moore control FSM for a multicycle MIPS-subset datapath
//          (lw, sw, R-type, beq, j, addi).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multicycle_control (
    input  logic                  Clk,
    input  logic                  Reset,
    multicycle_control_if.master  bus
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADDR   = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECUTE   = 4'd6,
        S_RCOMPLETE = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_DONE = 4'd11
    } state_t;

    typedef struct packed {
        logic [3:0] alu_ctl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctl_t;

    state_t     state;
    state_t     next_state;
    ctl_t       ctl;
    logic [3:0] funct_alu;
    logic       funct_ok;
    state_t     decode_target;
    logic       op_ok;
    logic       branch_take;

    // Moore outputs of a state; exec_* only matter for EXECUTE/RCOMPLETE
    function automatic ctl_t decode_ctl(input state_t s, input logic [3:0] exec_alu,
                                        input logic exec_ok);
        ctl_t c;
        c         = '0;
        c.alu_ctl = ALU_ADD;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE:    c.alu_src_b = 2'b11;
            S_MEMADDR, S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_ctl   = exec_alu;
            end
            // An unsupported funct seen in EXECUTE suppresses the writeback
            S_RCOMPLETE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = exec_ok;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_ctl   = ALU_SUB;
                c.pc_source = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_ADDI_DONE: c.reg_write = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (bus.Funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b100111: funct_alu = ALU_NOR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        op_ok         = 1'b1;
        decode_target = S_FETCH;
        case (bus.Opcode)
            OP_LW, OP_SW: decode_target = S_MEMADDR;
            OP_RTYPE:     decode_target = S_EXECUTE;
            OP_BEQ:       decode_target = S_BRANCH;
            OP_J:         decode_target = S_JUMP;
            OP_ADDI:      decode_target = S_ADDI_EXEC;
            default:      op_ok         = 1'b0;
        endcase
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:     next_state = S_DECODE;
            S_DECODE:    next_state = decode_target;
            S_MEMADDR:   next_state = (bus.Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:   next_state = S_MEMWB;
            S_EXECUTE:   next_state = S_RCOMPLETE;
            S_ADDI_EXEC: next_state = S_ADDI_DONE;
            default:     next_state = S_FETCH;
        endcase
    end

    // Outputs are registered alongside the state they belong to
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_FETCH;
            ctl   <= decode_ctl(S_FETCH, ALU_ADD, 1'b1);
        end else begin
            state <= next_state;
            ctl   <= decode_ctl(next_state, funct_alu, funct_ok);
        end
    end

    assign branch_take = (state == S_BRANCH) && bus.Zero_Flag;

    assign bus.ALU_Ctl  = ctl.alu_ctl;
    assign bus.ALUSrcA  = ctl.alu_src_a;
    assign bus.ALUSrcB  = ctl.alu_src_b;
    assign bus.PCSource = ctl.pc_source;
    assign bus.IorD     = ctl.iord;
    assign bus.RegDst   = ctl.reg_dst;
    assign bus.MemtoReg = ctl.mem_to_reg;
    assign bus.State    = state;

    // Strobes are held off for as long as Reset is high, whatever the state
    assign bus.PCWrite  = ~Reset & (ctl.pc_write | branch_take);
    assign bus.MemRead  = ~Reset & ctl.mem_read;
    assign bus.MemWrite = ~Reset & ctl.mem_write;
    assign bus.IRWrite  = ~Reset & ctl.ir_write;
    assign bus.RegWrite = ~Reset & ctl.reg_write;
    assign bus.Illegal  = ~Reset & (((state == S_DECODE)  & ~op_ok) |
                                    ((state == S_EXECUTE) & ~funct_ok));

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module : tb_multicycle_control
// Brief  : Directed scoreboard bench for multicycle_control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    multicycle_control_if bus ();

    multicycle_control dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic [21:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam int ADD = 4'b0010;
    localparam int SUB = 4'b0110;

    // {State, ALU_Ctl, ALUSrcA, ALUSrcB, PCSource, PCWrite, IorD, MemRead,
    //  MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, Illegal}
    function automatic logic [21:0] vec(input int st, input int alu, input int sa,
            input int sb, input int ps, input int pw, input int iord, input int mr,
            input int mw, input int irw, input int rd, input int m2r, input int rw,
            input int ill);
        return {st[3:0], alu[3:0], sa[0], sb[1:0], ps[1:0], pw[0], iord[0], mr[0],
                mw[0], irw[0], rd[0], m2r[0], rw[0], ill[0]};
    endfunction

    logic [21:0] e_fetch_rst, e_fetch, e_decode, e_decode_ill, e_memaddr, e_memread;
    logic [21:0] e_memwb, e_memwrite, e_memwrite_rst, e_exec_ill, e_rcomp, e_rcomp_nowr;
    logic [21:0] e_jump, e_addi_exec, e_addi_done;

    initial begin
        e_fetch_rst    = vec(0, ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_fetch        = vec(0, ADD, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        e_decode       = vec(1, ADD, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_decode_ill   = vec(1, ADD, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        e_memaddr      = vec(2, ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_memread      = vec(3, ADD, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        e_memwb        = vec(4, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        e_memwrite     = vec(5, ADD, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        e_memwrite_rst = vec(5, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        e_exec_ill     = vec(6, ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        e_rcomp        = vec(7, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        e_rcomp_nowr   = vec(7, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        e_jump         = vec(9, ADD, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        e_addi_exec    = vec(10, ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_addi_done    = vec(11, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    end

    // One cycle of stimulus; the expected outputs for that cycle are queued
    task automatic step(input string nm, input logic rst, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic [21:0] e);
        exp_t x;
        @(posedge Clk);
        #1;
        Reset         = rst;
        bus.Opcode    = op;
        bus.Funct     = fn;
        bus.Zero_Flag = z;
        x.name = nm;
        x.v    = e;
        q.push_back(x);
    endtask

    // Monitor: compares every presented output vector against the scoreboard
    initial begin
        exp_t        x;
        logic [21:0] act;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                x   = q.pop_front();
                act = {bus.State, bus.ALU_Ctl, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource,
                       bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                       bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.Illegal};
                checks++;
                if (act !== x.v) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", x.name, act, x.v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    logic [5:0] r_funct [6];
    int         r_alu   [6];

    initial begin
        bus.Opcode    = 6'b000000;
        bus.Funct     = 6'b000000;
        bus.Zero_Flag = 1'b0;
        r_funct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
        r_alu   = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

        step("reset_cyc1", 1, 6'b100011, 6'd0, 0, e_fetch_rst);
        step("reset_cyc2", 1, 6'b100011, 6'd0, 0, e_fetch_rst);

        step("lw_fetch",   0, 6'b100011, 6'd0, 0, e_fetch);
        step("lw_decode",  0, 6'b100011, 6'd0, 0, e_decode);
        step("lw_memaddr", 0, 6'b100011, 6'd0, 0, e_memaddr);
        step("lw_memread", 0, 6'b100011, 6'd0, 0, e_memread);
        step("lw_memwb",   0, 6'b100011, 6'd0, 0, e_memwb);

        step("sw_fetch",    0, 6'b101011, 6'd0, 0, e_fetch);
        step("sw_decode",   0, 6'b101011, 6'd0, 0, e_decode);
        step("sw_memaddr",  0, 6'b101011, 6'd0, 0, e_memaddr);
        step("sw_memwrite", 0, 6'b101011, 6'd0, 0, e_memwrite);

        for (int i = 0; i < 6; i++) begin
            step("r_fetch",   0, 6'b000000, r_funct[i], 0, e_fetch);
            step("r_decode",  0, 6'b000000, r_funct[i], 0, e_decode);
            step($sformatf("r_execute_funct_%b", r_funct[i]), 0, 6'b000000, r_funct[i], 0,
                 vec(6, r_alu[i], 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            step("r_rcomplete", 0, 6'b000000, r_funct[i], 0, e_rcomp);
        end

        step("rbad_fetch",     0, 6'b000000, 6'b000000, 0, e_fetch);
        step("rbad_decode",    0, 6'b000000, 6'b000000, 0, e_decode);
        step("rbad_execute",   0, 6'b000000, 6'b000000, 0, e_exec_ill);
        step("rbad_rcomplete", 0, 6'b000000, 6'b000000, 0, e_rcomp_nowr);

        step("addi_fetch", 0, 6'b001000, 6'd0, 0, e_fetch);
        step("addi_decode", 0, 6'b001000, 6'd0, 0, e_decode);
        step("addi_exec",  0, 6'b001000, 6'd0, 0, e_addi_exec);
        step("addi_done",  0, 6'b001000, 6'd0, 0, e_addi_done);

        step("beq1_fetch",  0, 6'b000100, 6'd0, 0, e_fetch);
        step("beq1_decode", 0, 6'b000100, 6'd0, 0, e_decode);
        step("beq1_branch", 0, 6'b000100, 6'd0, 1,
             vec(8, SUB, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("beq0_fetch",  0, 6'b000100, 6'd0, 1, e_fetch);
        step("beq0_decode", 0, 6'b000100, 6'd0, 1, e_decode);
        step("beq0_branch", 0, 6'b000100, 6'd0, 0,
             vec(8, SUB, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        step("j_fetch",  0, 6'b000010, 6'd0, 0, e_fetch);
        step("j_decode", 0, 6'b000010, 6'd0, 0, e_decode);
        step("j_jump",   0, 6'b000010, 6'd0, 0, e_jump);

        step("ill_fetch",  0, 6'b111111, 6'd0, 0, e_fetch);
        step("ill_decode", 0, 6'b111111, 6'd0, 0, e_decode_ill);

        step("swr_fetch",    0, 6'b101011, 6'd0, 0, e_fetch);
        step("swr_decode",   0, 6'b101011, 6'd0, 0, e_decode);
        step("swr_memaddr",  0, 6'b101011, 6'd0, 0, e_memaddr);
        step("swr_memwrite_in_reset", 1, 6'b101011, 6'd0, 0, e_memwrite_rst);
        step("swr_after_reset_fetch", 0, 6'b000010, 6'd0, 0, e_fetch);
        step("swr_after_reset_decode", 0, 6'b000010, 6'd0, 0, e_decode);

        @(negedge Clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
